// File: rtl/div_result_display_pkg.sv
// -----------------------------------------------------------------------------
// div_result_display_pkg
// Shared constants for the quotient/remainder display stage:
//   - FSM state encoding (IDLE, CONV, COMMIT, SHOW)
//   - 7-segment codes (gfedcba, active-low) plus the blank code
//   - digit-position bases for the remainder and quotient fields
//   - number of shift-add-3 iterations for a 7-bit operand
//   - helper functions for segment encoding and BCD nibble adjustment
// -----------------------------------------------------------------------------
package div_result_display_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CONV   = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;
    localparam state_t ST_SHOW   = 2'd3;

    localparam int NUM_ITER = 7;

    localparam logic [2:0] REM_BASE = 3'd0;
    localparam logic [2:0] QUO_BASE = 3'd4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Map one BCD digit to its active-low segment pattern; non-decimal
    // nibbles never occur in a valid conversion and map to blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after
    // the following shift, so add 3 to force the carry into the next digit.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_result_display_bin7_to_bcd3.sv
// -----------------------------------------------------------------------------
// bin7_to_bcd3
// Sequential shift-add-3 (double-dabble) converter, 7-bit binary to three
// BCD digits. One iteration per cycle while 'step' is high; seven steps after
// 'load' give the final result on 'bcd'.
//   CLK   in   clock
//   RSTN  in   synchronous active-low reset
//   load  in   capture 'bin' and clear the BCD accumulator
//   step  in   perform one adjust-and-shift iteration
//   bin   in   [6:0] binary operand
//   bcd   out  [11:0] {hundreds, tens, units}
// -----------------------------------------------------------------------------
module bin7_to_bcd3
    import div_result_display_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        load,
    input  logic        step,
    input  logic [6:0]  bin,
    output logic [11:0] bcd
);

    logic [6:0]  bin_r;
    logic [11:0] bcd_r;
    logic [11:0] adj_s;

    // Per-nibble add-3 correction applied before each shift.
    always_comb begin
        adj_s = {bcd_adjust(bcd_r[11:8]), bcd_adjust(bcd_r[7:4]), bcd_adjust(bcd_r[3:0])};
    end

    // Operand shift register and BCD accumulator.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            bin_r <= 7'd0;
            bcd_r <= 12'd0;
        end else if (load) begin
            bin_r <= bin;
            bcd_r <= 12'd0;
        end else if (step) begin
            {bcd_r, bin_r} <= {adj_s, bin_r} << 1;
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
        end
    end

    assign bcd = bcd_r;

endmodule

// File: rtl/div_result_display.sv
// -----------------------------------------------------------------------------
// div_result_display
// Captures a quotient/remainder pair through a valid/ready handshake, converts
// both to BCD with two shift-add-3 engines, and drives an 8-digit active-low
// multiplexed 7-segment display: quotient on idx 6..4, remainder on idx 2..0,
// idx 7 and idx 3 always blank, leading zeros blanked.
//   REFRESH_DIV  CLK cycles per lit digit (>= 2)
//   CLK          in   system clock
//   RSTN         in   synchronous active-low reset
//   res_valid    in   result presented
//   res_ready    out  result can be accepted (IDLE or SHOW)
//   quotient     in   [6:0]
//   remainder    in   [6:0]
//   busy         out  conversion in progress (CONV or COMMIT)
//   seg          out  [6:0] segments, active-low, seg[0]=a .. seg[6]=g
//   an           out  [7:0] anodes, active-low, an[7] leftmost
// -----------------------------------------------------------------------------
module div_result_display
    import div_result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [6:0] quotient,
    input  logic [6:0] remainder,
    output logic       busy,
    output logic [6:0] seg,
    output logic [7:0] an
);

    localparam int CNT_W = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       LAST_ITER = 3'(NUM_ITER - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [2:0]       iter_r;
    logic             res_ready_r;
    logic             busy_r;
    logic             transfer_s;
    logic             step_s;

    logic [11:0]      quo_bcd_s;
    logic [11:0]      rem_bcd_s;
    logic [11:0]      quo_disp_r;
    logic [11:0]      rem_disp_r;
    logic             disp_valid_r;

    logic [CNT_W-1:0] refresh_cnt_r;
    logic [2:0]       idx_r;
    logic [2:0]       idx_nxt_s;
    logic             wrap_s;
    logic [2:0]       base_s;
    logic [2:0]       pos_s;
    logic [11:0]      opnd_s;
    logic [3:0]       digit_s;
    logic             lit_s;
    logic [7:0]       an_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;

    assign transfer_s = res_valid && res_ready_r;
    assign step_s     = (state_r == ST_CONV);

    bin7_to_bcd3 u_quo_bcd (
        .CLK  (CLK),
        .RSTN (RSTN),
        .load (transfer_s),
        .step (step_s),
        .bin  (quotient),
        .bcd  (quo_bcd_s)
    );

    bin7_to_bcd3 u_rem_bcd (
        .CLK  (CLK),
        .RSTN (RSTN),
        .load (transfer_s),
        .step (step_s),
        .bin  (remainder),
        .bcd  (rem_bcd_s)
    );

    // Next-state logic of the capture/convert FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_SHOW: begin
                if (transfer_s) begin
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CONV: begin
                if (iter_r == LAST_ITER) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_COMMIT: state_nxt_s = ST_SHOW;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, iteration counter and registered handshake/status outputs.
    // ready/busy are decoded from the next state so they track state_r exactly.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_r     <= ST_IDLE;
            iter_r      <= 3'd0;
            res_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            res_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_SHOW);
            busy_r      <= (state_nxt_s == ST_CONV) || (state_nxt_s == ST_COMMIT);
            if (transfer_s) begin
                iter_r <= 3'd0;
            end else if (state_r == ST_CONV) begin
                iter_r <= iter_r + 3'd1;
            end else begin
                iter_r <= iter_r;
            end
        end
    end

    // Display registers: the old result stays visible until COMMIT.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            quo_disp_r   <= 12'd0;
            rem_disp_r   <= 12'd0;
            disp_valid_r <= 1'b0;
        end else if (state_r == ST_COMMIT) begin
            quo_disp_r   <= quo_bcd_s;
            rem_disp_r   <= rem_bcd_s;
            disp_valid_r <= 1'b1;
        end else begin
            quo_disp_r   <= quo_disp_r;
            rem_disp_r   <= rem_disp_r;
            disp_valid_r <= disp_valid_r;
        end
    end

    assign wrap_s    = (refresh_cnt_r == CNT_LAST);
    assign idx_nxt_s = idx_r + 3'd1;

    // Decode the digit that becomes lit at the next index step, including
    // leading-zero blanking of the hundreds and tens positions.
    always_comb begin
        if (idx_nxt_s >= QUO_BASE) begin
            base_s = QUO_BASE;
            opnd_s = quo_disp_r;
        end else begin
            base_s = REM_BASE;
            opnd_s = rem_disp_r;
        end
        pos_s = idx_nxt_s - base_s;
        case (pos_s)
            3'd0: begin
                digit_s = opnd_s[3:0];
                lit_s   = 1'b1;
            end
            3'd1: begin
                digit_s = opnd_s[7:4];
                lit_s   = (opnd_s[11:8] != 4'd0) || (opnd_s[7:4] != 4'd0);
            end
            3'd2: begin
                digit_s = opnd_s[11:8];
                lit_s   = (opnd_s[11:8] != 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                lit_s   = 1'b0;
            end
        endcase
        if (lit_s && disp_valid_r) begin
            an_nxt_s  = ~(8'd1 << idx_nxt_s);
            seg_nxt_s = seg_encode(digit_s);
        end else begin
            an_nxt_s  = 8'hFF;
            seg_nxt_s = SEG_BLANK;
        end
    end

    // Refresh counter, digit index and registered anode/segment drive.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            refresh_cnt_r <= '0;
            idx_r         <= 3'd0;
            an_r          <= 8'hFF;
            seg_r         <= SEG_BLANK;
        end else if (wrap_s) begin
            refresh_cnt_r <= '0;
            idx_r         <= idx_nxt_s;
            an_r          <= an_nxt_s;
            seg_r         <= seg_nxt_s;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
            idx_r         <= idx_r;
            an_r          <= an_r;
            seg_r         <= seg_r;
        end
    end

    assign res_ready = res_ready_r;
    assign busy      = busy_r;
    assign an        = an_r;
    assign seg       = seg_r;

endmodule

// File: tb/tb_div_result_display.sv
// -----------------------------------------------------------------------------
// tb_div_result_display
// Self-checking bench for div_result_display with REFRESH_DIV = 4. Expected
// digits come from plain decimal arithmetic on the transferred values.
// -----------------------------------------------------------------------------
module tb_div_result_display;

    localparam int RD = 4;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic       res_valid;
    logic       res_ready;
    logic [6:0] quotient;
    logic [6:0] remainder;
    logic       busy;
    logic [6:0] seg;
    logic [7:0] an;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int hs_bad    = 0;

    always #5 CLK = ~CLK;

    div_result_display #(.REFRESH_DIV(RD)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .seg       (seg),
        .an        (an)
    );

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected segment pattern at display position idx (7F = blank).
    function automatic logic [6:0] exp_pos(input int q, input int r, input int idx);
        int v;
        if (idx == 3 || idx == 7) return 7'h7F;
        v = (idx >= 4) ? q : r;
        case (idx % 4)
            0: return exp_seg(v % 10);
            1: return (v >= 10)  ? exp_seg((v / 10) % 10) : 7'h7F;
            2: return (v >= 100) ? exp_seg(v / 100) : 7'h7F;
            default: return 7'h7F;
        endcase
    endfunction

    // Transfer one pair starting from the current (negedge) time; returns busy length.
    task automatic do_transfer(input int q, input int r, output int busy_cycles);
        for (int i = 0; i < 40 && !res_ready; i++) @(negedge CLK);
        res_valid = 1'b1;
        quotient  = 7'(q);
        remainder = 7'(r);
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
        quotient  = 7'($urandom);
        remainder = 7'($urandom);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (res_ready !== !busy) hs_bad++;
            if (busy) busy_cycles++;
            else break;
        end
    endtask

    // Observe two full scans and compare every position against the model.
    task automatic scan_check(input string name, input int q, input int r);
        logic [6:0] seen_seg [8];
        bit         seen     [8];
        int         bad = 0;
        logic [6:0] got;
        for (int k = 0; k < 8; k++) begin
            seen[k] = 1'b0;
            seen_seg[k] = 7'h7F;
        end
        repeat (RD + 1) @(negedge CLK);
        for (int c = 0; c < 16 * RD; c++) begin
            @(negedge CLK);
            if (an === 8'hFF) begin
                if (seg !== 7'h7F) bad++;
            end else if ($countones(~an) != 1) begin
                bad++;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    if (!an[k]) begin
                        if (seen[k] && seen_seg[k] !== seg) bad++;
                        seen[k] = 1'b1;
                        seen_seg[k] = seg;
                    end
                end
            end
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL %s scan_consistency: bad=%0d required 0", name, bad);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            got = seen[k] ? seen_seg[k] : 7'h7F;
            check_cnt++;
            if (got !== exp_pos(q, r, k))
                $display("FAIL %s idx%0d: seg=%b required %b (q=%0d r=%0d)", name, k, got, exp_pos(q, r, k), q, r);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        RSTN = 1'b0;
        res_valid = 1'b1;
        quotient = 7'd5;
        remainder = 7'd5;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        res_valid = 1'b0;
        check_cnt++;
        if (res_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_status: ready=%b busy=%b required 1/0", res_ready, busy);
        else pass_cnt++;
        for (int c = 0; c < 16 * RD; c++) begin
            @(negedge CLK);
            if (an !== 8'hFF || seg !== 7'h7F || busy !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL reset_blank: bad cycles=%0d required 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_directed(input string name, input int q, input int r);
        int bc;
        do_transfer(q, r, bc);
        check_cnt++;
        if (bc !== 8) $display("FAIL %s busy_len: got %0d required 8", name, bc);
        else pass_cnt++;
        scan_check(name, q, r);
    endtask

    task automatic test_busy_ignore(input int oq, input int orr);
        int qa = 55, ra = 17, bc = 0, bad = 0;
        res_valid = 1'b1;
        quotient = 7'(qa);
        remainder = 7'(ra);
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            res_valid = (i == 2);
            quotient  = 7'd9;
            remainder = 7'd9;
            if (!busy) break;
            bc++;
            if (an !== 8'hFF) begin
                for (int k = 0; k < 8; k++)
                    if (!an[k] && seg !== exp_pos(oq, orr, k)) bad++;
            end
        end
        res_valid = 1'b0;
        check_cnt++;
        if (bc !== 8) $display("FAIL busy_ignore_len: got %0d required 8", bc);
        else pass_cnt++;
        check_cnt++;
        if (bad !== 0) $display("FAIL display_hold: bad=%0d required 0", bad);
        else pass_cnt++;
        scan_check("busy_ignore", qa, ra);
    endtask

    task automatic test_back_to_back();
        int q, r, bc;
        for (int rep = 0; rep < 3; rep++) begin
            for (int j = 0; j < 3; j++) begin
                q = (j == 0 && rep == 0) ? 99 : int'($urandom_range(0, 127));
                r = (j == 1 && rep == 1) ? 10 : int'($urandom_range(0, 127));
                do_transfer(q, r, bc);
                check_cnt++;
                if (bc !== 8) $display("FAIL b2b_busy_len: got %0d required 8", bc);
                else pass_cnt++;
            end
            scan_check("back_to_back", q, r);
        end
    endtask

    task automatic test_reset_mid_conv();
        int bc, bad = 0;
        res_valid = 1'b1;
        quotient = 7'd88;
        remainder = 7'd45;
        @(posedge CLK);
        #1;
        res_valid = 1'b0;
        repeat (4) @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        check_cnt++;
        if (res_ready !== 1'b1 || busy !== 1'b0 || an !== 8'hFF || seg !== 7'h7F)
            $display("FAIL midconv_reset: ready=%b busy=%b an=%h seg=%h required 1/0/ff/7f",
                     res_ready, busy, an, seg);
        else pass_cnt++;
        RSTN = 1'b1;
        for (int c = 0; c < 16 * RD; c++) begin
            @(negedge CLK);
            if (an !== 8'hFF || busy !== 1'b0) bad++;
        end
        check_cnt++;
        if (bad !== 0) $display("FAIL midconv_aborted: bad=%0d required 0", bad);
        else pass_cnt++;
        do_transfer(64, 3, bc);
        check_cnt++;
        if (bc !== 8) $display("FAIL after_reset_busy_len: got %0d required 8", bc);
        else pass_cnt++;
        scan_check("after_reset", 64, 3);
    endtask

    initial begin
        RSTN = 1'b0;
        res_valid = 1'b0;
        quotient = 7'd0;
        remainder = 7'd0;
        test_reset();
        test_directed("q42_r5", 42, 5);
        test_directed("q127_r100", 127, 100);
        test_directed("q0_r0", 0, 0);
        test_busy_ignore(0, 0);
        test_back_to_back();
        test_reset_mid_conv();
        check_cnt++;
        if (hs_bad !== 0) $display("FAIL ready_vs_busy: bad=%0d required 0", hs_bad);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
